// File: rtl/conv_out_streamer.sv
// Regenerates a valid strobe for the convolver result word, drops window warm-up
// words at frame start, and streams the rest out as AXI-Stream through a small FWFT FIFO.
module conv_out_streamer #(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned PIPE_LATENCY = 4,
  parameter int unsigned SKIP_WORDS   = 2,
  parameter int unsigned FRAME_WORDS  = 9801,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic                        i_sof,
  input  logic [NB_DATA-1:0]          i_conv_data,
  output logic [NB_DATA-1:0]          o_tdata,
  output logic                        o_tvalid,
  input  logic                        i_tready,
  output logic                        o_tlast,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned EW  = NB_DATA + 1;
  localparam int unsigned SKW = $clog2(SKIP_WORDS + 2);
  localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);

  logic [PIPE_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [PIPE_LATENCY-1:0] sof_pipe_q, sof_pipe_d;
  logic [SKW-1:0]          skip_cnt_q, skip_cnt_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d, cnt_base;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [NB_DATA-1:0]      tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    ovf_q, ovf_d;

  logic          v_d, sof_d, skipping, accept, acc_last;
  logic          pop, full, push;
  logic [EW-1:0] wentry, head;

  assign v_d    = vld_pipe_q[PIPE_LATENCY-1];
  assign sof_d  = sof_pipe_q[PIPE_LATENCY-1];
  assign wentry = {acc_last, i_conv_data};

  // Valid/sof delay line matching the convolver pipeline depth
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    sof_pipe_d    = sof_pipe_q;
    vld_pipe_d[0] = i_valid;
    sof_pipe_d[0] = i_valid & i_sof;
    for (int unsigned i = 1; i < PIPE_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      sof_pipe_d[i] = sof_pipe_q[i-1];
    end
  end

  // Warm-up skip and frame word counting; sof restarts both
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    word_cnt_d = word_cnt_q;
    accept     = 1'b0;
    acc_last   = 1'b0;
    cnt_base   = sof_d ? '0 : word_cnt_q;
    skipping   = sof_d ? (SKIP_WORDS != 0) : (skip_cnt_q != '0);
    if (v_d) begin
      if (skipping) begin
        skip_cnt_d = sof_d ? SKW'(SKIP_WORDS - 1) : skip_cnt_q - SKW'(1);
        word_cnt_d = cnt_base;
      end else begin
        accept     = 1'b1;
        acc_last   = (cnt_base == WCW'(FRAME_WORDS - 1));
        word_cnt_d = acc_last ? '0 : cnt_base + WCW'(1);
        skip_cnt_d = '0;
      end
    end
  end

  // FIFO bookkeeping; the registered head is precomputed from post-edge pointers
  always_comb begin
    pop      = tvalid_q & i_tready;
    full     = (level_q == LW'(FIFO_DEPTH));
    push     = accept & (~full | pop);
    ovf_d    = ovf_q | (accept & full & ~pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    tvalid_d = (level_d != '0);
    head     = mem_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head = wentry;
    end
    if (level_d == '0) begin
      head = '0;
    end
    {tlast_d, tdata_d} = head;
  end

  // Storage needs no reset: pointers and level define what is live
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wentry;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_pipe_q <= '0;
      sof_pipe_q <= '0;
      skip_cnt_q <= '0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sof_pipe_q <= sof_pipe_d;
      skip_cnt_q <= skip_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_tdata    = tdata_q;
  assign o_tlast    = tlast_q;
  assign o_tvalid   = tvalid_q;
  assign o_overflow = ovf_q;
  assign o_level    = level_q;

endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
Output-side companion of the convolver datapath. It takes the packed 4-pixel result word produced by the convolver array, which has no valid and no backpressure, and regenerates a valid strobe aligned to the pipeline latency. It discards the warm-up words at frame start and emits the result as an AXI-Stream master (tdata/tvalid/tready/tlast) through a small skid FIFO toward the DMA/S2MM side.

Parameters:
NB_DATA, 32, width of packed result word (4 x 8-bit pixels, pixel0 in bits [7:0]).
PIPE_LATENCY, 4, cycles from i_valid at the convolver input to the matching word on i_conv_data; must be >= 1.
SKIP_WORDS, 2, valid words discarded after each start of frame (window warm-up); 0 means no skip.
FRAME_WORDS, 9801, accepted output words per frame; tlast goes on the last one.
FIFO_DEPTH, 16, output FIFO entries; must be a power of 2 and >= 2.

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_valid  in  1  same strobe that qualifies the convolver input word.
i_sof  in  1  start-of-frame; meaningful only with i_valid=1.
i_conv_data  in  NB_DATA  packed convolver output word.
o_tdata  out  NB_DATA  AXI-Stream data.
o_tvalid  out  1  AXI-Stream valid.
i_tready  in  1  AXI-Stream ready from the downstream sink.
o_tlast  out  1  high on the last word of a frame.
o_overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (i_reset=0, asynchronous): delay line, counters, FIFO pointers and o_overflow clear. o_tvalid=0, o_tlast=0, o_tdata=0, o_level=0. Reset asserted mid-frame discards all buffered words.
- Delay line: a PIPE_LATENCY-stage shift register carries {i_valid, i_sof} and produces v_d and sof_d, aligned with i_conv_data.
- Skip counter:
  - v_d & sof_d loads skip_cnt = SKIP_WORDS-1 and clears word_cnt. The sof word itself is discarded when SKIP_WORDS > 0.
  - While skip_cnt > 0, each v_d word is discarded and skip_cnt decrements.
  - If SKIP_WORDS=0, the sof word is accepted.
- Accept: a v_d word that is not skipped is "accepted".
  - last = (word_cnt == FRAME_WORDS-1).
  - word_cnt increments, wrapping to 0 after the last word.
  - A word with v_d=0 is ignored entirely.
- FIFO push: each accepted word pushes {last, data}.
  - Full with no pop in the same cycle: the word is dropped and o_overflow sets until reset. word_cnt still advances, so frame alignment is preserved even though the dropped tlast is lost.
  - Full with a pop in the same cycle: the push succeeds, no overflow, and o_level is unchanged.
- FIFO output, first-word-fall-through:
  - o_tvalid = not empty.
  - o_tdata and o_tlast reflect the head entry and are registered.
  - Pop on o_tvalid & i_tready.
  - While o_tvalid=1 and i_tready=0, o_tdata and o_tlast hold stable and o_tvalid stays 1.
- Latency: a word accepted at cycle t into an empty FIFO is visible with o_tvalid=1 at t+1. End-to-end latency from i_valid is PIPE_LATENCY+1 cycles.
- Empty FIFO with simultaneous push and pop: no pop occurs (o_tvalid=0 that cycle); the word appears next cycle.
- New frame: sof_d arriving mid-frame restarts word_cnt and the skip sequence. No tlast is generated for the truncated frame, and words already buffered are emitted unchanged.
- o_level: pointer difference, range 0..FIFO_DEPTH, updated on the same edge as push/pop.

Test Plan:
1. Reset: drive i_reset=0 with random inputs -> o_tvalid=0, o_tdata=0, o_tlast=0, o_overflow=0, o_level=0. Release with i_valid=0 -> outputs stay 0.
2. Latency/skip (PIPE_LATENCY=4, SKIP_WORDS=2): i_sof=1 with i_valid=1 at cycle 0, then i_valid=1 continuously; bench drives i_conv_data=0xA0000000+n at cycle n+4; i_tready=1 -> first o_tvalid at cycle 7 with o_tdata=0xA0000002, then one word per cycle in order.
3. tlast/wrap (FRAME_WORDS=8, SKIP_WORDS=0): 10 consecutive valid words after sof -> o_tlast=1 only on the 8th word output. Words 9 and 10 have tlast=0, and word 16 would carry tlast.
4. Backpressure (FIFO_DEPTH=4): i_tready=0, accept 6 words D0..D5 -> o_level=4, o_overflow=1 after D4. Raising i_tready -> D0..D3 emitted in order, then o_tvalid=0 and o_overflow remains 1.
5. Full push+pop: FIFO full, i_tready=1, and an accepted word in the same cycle -> o_overflow stays 0, o_level stays 4, FIFO order preserved.
6. Async reset mid-frame: assert i_reset=0 between clock edges with o_level=3 -> o_tvalid=0 and o_level=0 immediately. After release, a new sof frame restarts skip and tlast counting from 0.
